if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the 5-stage pipeline; it is the producer side of the IF/ID pipeline register.
- Owns the fetch PC and runs a single-outstanding request/grant/response handshake to instruction memory.
- Presents one fetched instruction at a time as pc/ins with fetch_valid to IF/ID.
- Obeys the same stall (enable_if) and redirect (pcsrc) controls that IF/ID uses; a bubble is pc=0, ins=0.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- PC_STEP, 4: sequential PC increment in bytes.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- enable_if  in  1  1 = IF/ID accepts this cycle; 0 = stall.
- pcsrc  in  1  1 = redirect fetch to branch_target (taken branch/jump).
- branch_target  in  32  redirect address; bits [1:0] ignored (forced 0).
- imem_req  out  1  memory request valid.
- imem_addr  out  32  request address, word aligned.
- imem_gnt  in  1  request accepted this cycle (only meaningful while imem_req=1).
- imem_rvalid  in  1  response data valid; arrives at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- pc  out  32  address of ins; 0 when fetch_valid=0.
- ins  out  32  fetched instruction; 0 when fetch_valid=0.
- fetch_valid  out  1  pc/ins hold a real instruction.

Behaviour:
- Internal state: fetch_pc[31:0], hold_pc, hold_ins, and FSM {S_REQ, S_WAIT, S_HOLD, S_DROP}.
- Reset (async, any time, including mid-transaction): state=S_REQ, fetch_pc=RESET_PC, hold regs=0. Outputs read pc=0, ins=0, fetch_valid=0, imem_req=0 while rst=1. Any rvalid belonging to a pre-reset request is ignored.
- S_REQ:
  - imem_req=1, imem_addr=fetch_pc; addr stays stable until gnt.
  - gnt=1 and pcsrc=0 -> S_WAIT.
  - pcsrc=1 and gnt=0 -> fetch_pc=target, stay S_REQ; the new address is driven next cycle.
  - pcsrc=1 and gnt=1 -> fetch_pc=target, go to S_DROP (the granted stale request's response must be discarded).
- S_WAIT:
  - imem_req=0.
  - rvalid=1 and pcsrc=0 -> hold_pc=fetch_pc, hold_ins=rdata, go to S_HOLD.
  - pcsrc=1 and rvalid=0 -> fetch_pc=target, go to S_DROP.
  - pcsrc=1 and rvalid=1 -> discard data, fetch_pc=target, go to S_REQ.
- S_HOLD:
  - fetch_valid=1, pc=hold_pc, ins=hold_ins; imem_req=0.
  - pcsrc=1 (priority over enable_if) -> fetch_pc=target, go to S_REQ. The held instruction is dropped and not counted as consumed.
  - enable_if=1 and pcsrc=0 -> instruction consumed; fetch_pc=fetch_pc+PC_STEP, go to S_REQ.
  - enable_if=0 -> stay; outputs stable for the whole stall.
- S_DROP:
  - imem_req=0.
  - Wait for rvalid, discard the data, then go to S_REQ.
  - pcsrc=1 again -> overwrite fetch_pc with the new target; still wait for the stale rvalid.
- rvalid in S_REQ or S_HOLD is a protocol error and is ignored.
- Arithmetic: PC increment is mod 2^32; 32'hFFFF_FFFC + 4 = 0.
- Latency: gnt in cycle N, rvalid in N+k (k>=1), fetch_valid in N+k+1. Peak throughput is 1 instruction per 3 cycles (req, rvalid, hold+consume).
- fetch_valid, pc, ins and imem_req are decoded from registered state only (no combinational path from rvalid/pcsrc to outputs). imem_addr mirrors fetch_pc.

Test Plan:
- Reset release, RESET_PC=0, memory gnt same cycle, rvalid 1 cycle later with 32'h0000_0013; enable_if=1 -> pc/ins = 0/13, then 4/next, then 8/...; fetch_valid pulses 1 cycle in every 3.
- Stall: enable_if=0 for 5 cycles while in S_HOLD with pc=0x8 -> pc/ins/fetch_valid stable; imem_req=0; resumes at 0xC after release.
- Redirect in S_WAIT: pcsrc=1 with target 0x100 (rvalid comes 2 cycles later) -> stale data never appears at ins; next imem_addr=0x100; next valid pc=0x100.
- Simultaneous pcsrc+gnt in S_REQ, target 0x203 -> S_DROP; stale rvalid discarded; imem_addr=0x200 (low bits cleared).
- Simultaneous pcsrc and enable_if in S_HOLD -> redirect wins; fetch_pc=target, not pc+4.
- Wrap and reset: RESET_PC=32'hFFFF_FFFC, consume one instruction -> next imem_addr=0. Assert rst while in S_WAIT -> outputs 0 immediately; a late rvalid after release is ignored; refetch from RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, runs a single-outstanding
// req/gnt/rvalid handshake to instruction memory and presents pc/ins to IF/ID.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_if,
    input  logic        pcsrc,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ins,
    output logic        fetch_valid
);

    localparam logic [31:0] RESET_PC_A = RESET_PC & ~32'h3;
    localparam logic [31:0] STEP       = 32'(PC_STEP);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_ins_q, hold_ins_d;
    logic [31:0] target_c;

    assign target_c = branch_target & ~32'h3;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC_A;
            hold_pc_q  <= 32'h0;
            hold_ins_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            hold_pc_q  <= hold_pc_d;
            hold_ins_q <= hold_ins_d;
        end
    end

    // Next-state logic; a redirect always rewrites fetch_pc, whatever the state
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        hold_pc_d  = hold_pc_q;
        hold_ins_d = hold_ins_q;

        case (state_q)
            S_REQ: begin
                if (pcsrc) begin
                    fetch_pc_d = target_c;
                    if (imem_gnt) begin
                        state_d = S_DROP;
                    end
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (pcsrc) begin
                    fetch_pc_d = target_c;
                    state_d    = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    hold_pc_d  = fetch_pc_q;
                    hold_ins_d = imem_rdata;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (pcsrc) begin
                    fetch_pc_d = target_c;
                    state_d    = S_REQ;
                end else if (enable_if) begin
                    fetch_pc_d = fetch_pc_q + STEP;
                    state_d    = S_REQ;
                end
            end
            S_DROP: begin
                // Stale response still owed by memory; swallow it before re-requesting
                if (pcsrc) begin
                    fetch_pc_d = target_c;
                end
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Outputs decoded from registered state; request is masked during reset
    assign imem_req    = (state_q == S_REQ) && !rst;
    assign imem_addr   = fetch_pc_q;
    assign fetch_valid = (state_q == S_HOLD);
    assign pc          = fetch_valid ? hold_pc_q  : 32'h0;
    assign ins         = fetch_valid ? hold_ins_q : 32'h0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed cycle table, a hand-written
// reset-during-wait sequence, then randomized traffic against a program-order model.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_if;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        fetch_valid;

    int checks = 0;
    int errors = 0;

    if_fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .enable_if(enable_if), .pcsrc(pcsrc),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc(pc), .ins(ins), .fetch_valid(fetch_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, en, pcsrc;
        logic [31:0] tgt;
        logic        gnt, rv;
        logic [31:0] rd;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_ins;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic en, input logic ps, input logic [31:0] tgt,
                       input logic gnt, input logic rv, input logic [31:0] rd,
                       input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                       input logic [31:0] e_pc, input logic [31:0] e_ins);
        vec_t v;
        v.rst = r; v.en = en; v.pcsrc = ps; v.tgt = tgt; v.gnt = gnt; v.rv = rv; v.rd = rd;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_ins = e_ins;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_ins);
        chk({tag, ".imem_req"}, 32'(imem_req), 32'(e_req));
        chk({tag, ".imem_addr"}, imem_addr, e_addr);
        chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(e_valid));
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".ins"}, ins, e_ins);
    endtask

    task automatic drive(input logic r, input logic en, input logic ps, input logic [31:0] tgt,
                         input logic gnt, input logic rv, input logic [31:0] rd);
        rst = r; enable_if = en; pcsrc = ps; branch_target = tgt;
        imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd;
    endtask

    // Instruction memory contents for the random phase
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    // Random-phase state
    logic [31:0] exp_pc;
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    logic        p_en, p_ps, p_valid;
    logic [31:0] p_tgt;
    int          consumed;
    int          idle;
    logic        gnt_r, rv_r, ps_r, en_r;
    logic [31:0] rd_r, tgt_r;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // ---- directed table: one row per cycle, outputs are the state before the row's edge
        //   rst en ps tgt             gnt rv rdata           req addr           v  pc             ins
        add(1, 0, 0, 32'h0,         0, 0, 32'h0,          0, RST_PC,        0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, RST_PC,        0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 1, 32'h0000_0013,  0, RST_PC,        0, 32'h0,         32'h0);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, RST_PC,        1, RST_PC,        32'h0000_0013);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h0,         0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 1, 32'h0010_0093,  0, 32'h0,         0, 32'h0,         32'h0);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, 32'h0,         1, 32'h0,         32'h0010_0093);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h4,         0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 1, 32'h0020_0113,  0, 32'h4,         0, 32'h0,         32'h0);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, 32'h4,         1, 32'h4,         32'h0020_0113);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h8,         0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 1, 32'h0030_0193,  0, 32'h8,         0, 32'h0,         32'h0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 32'h0,     0, 0, 32'h0,          0, 32'h8,         1, 32'h8,         32'h0030_0193);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, 32'h8,         1, 32'h8,         32'h0030_0193);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'hC,         0, 32'h0,         32'h0);
        add(0, 0, 1, 32'h100,       0, 0, 32'h0,          0, 32'hC,         0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h100,       0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 1, 32'hDEAD_BEEF,  0, 32'h100,       0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h100,       0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 1, 32'h0040_0213,  0, 32'h100,       0, 32'h0,         32'h0);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, 32'h100,       1, 32'h100,       32'h0040_0213);
        add(0, 0, 1, 32'h203,       1, 0, 32'h0,          1, 32'h104,       0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h200,       0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 1, 32'hBAD0_BAD0,  0, 32'h200,       0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h200,       0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 1, 32'h0050_0293,  0, 32'h200,       0, 32'h0,         32'h0);
        add(0, 1, 1, 32'h300,       0, 0, 32'h0,          0, 32'h200,       1, 32'h200,       32'h0050_0293);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h300,       0, 32'h0,         32'h0);
        add(0, 0, 1, 32'h404,       0, 0, 32'h0,          1, 32'h300,       0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h404,       0, 32'h0,         32'h0);
        add(0, 0, 1, 32'h500,       0, 1, 32'hCAFE_0001,  0, 32'h404,       0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 1, 32'hCAFE_0002,  1, 32'h500,       0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         1, 0, 32'h0,          1, 32'h500,       0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 1, 32'h0000_0011,  0, 32'h500,       0, 32'h0,         32'h0);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,          0, 32'h500,       1, 32'h500,       32'h0000_0011);
        add(0, 0, 0, 32'h0,         0, 1, 32'h0000_0099,  0, 32'h500,       1, 32'h500,       32'h0000_0011);
        add(0, 1, 0, 32'h0,         0, 0, 32'h0,          0, 32'h500,       1, 32'h500,       32'h0000_0011);
        add(0, 0, 0, 32'h0,         0, 0, 32'h0,          1, 32'h504,       0, 32'h0,         32'h0);

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].pcsrc, vecs[i].tgt,
                  vecs[i].gnt, vecs[i].rv, vecs[i].rd);
            #1;
            chk_outs($sformatf("row%0d", i), vecs[i].e_req, vecs[i].e_addr,
                     vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_ins);
            @(posedge clk); #1;
        end

        // ---- reset asserted mid-transaction, then a late response after release
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk_outs("rst_wait", 1'b0, RST_PC, 1'b0, 32'h0, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk_outs("rst_async", 1'b0, RST_PC, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_DEAD);
        #1;
        chk_outs("rst_rel", 1'b1, RST_PC, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        #1;
        chk_outs("rst_late", 1'b1, RST_PC, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0073);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk_outs("rst_refetch", 1'b0, RST_PC, 1'b1, RST_PC, 32'h0000_0073);
        @(posedge clk); #1;
        #1;
        chk_outs("rst_wrap", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

        // ---- randomized traffic against a program-order model
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_pc = RST_PC; pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
        p_en = 1'b0; p_ps = 1'b0; p_valid = 1'b0; p_tgt = 32'h0;
        consumed = 0; idle = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            // advance model with the previous cycle's handshake
            if (p_ps)                exp_pc = p_tgt & ~32'h3;
            else if (p_valid && p_en) begin exp_pc = exp_pc + 32'd4; consumed++; end

            if (imem_req) chk("rnd.imem_addr", imem_addr, exp_pc);
            if (fetch_valid) begin
                chk("rnd.pc", pc, exp_pc);
                chk("rnd.ins", ins, memf(exp_pc));
                idle = 0;
            end else begin
                chk("rnd.bubble", {pc | ins}, 32'h0);
                idle++;
            end
            if (idle == 200) begin
                errors++;
                $display("FAIL rnd.liveness: no valid instruction for %0d cycles", idle);
            end

            // memory: single outstanding, response 1..3 cycles after grant
            rv_r = 1'b0; rd_r = 32'h0;
            if (pend) begin
                if (pend_cnt == 0) begin rv_r = 1'b1; rd_r = memf(pend_addr); pend = 1'b0; end
                else pend_cnt--;
            end else if ($urandom_range(0, 9) == 0) begin
                rv_r = 1'b1; rd_r = $urandom;
            end
            gnt_r = imem_req && ($urandom_range(0, 9) < 6);
            if (gnt_r) begin pend = 1'b1; pend_addr = imem_addr; pend_cnt = $urandom_range(0, 2); end
            ps_r  = ($urandom_range(0, 7) == 0);
            tgt_r = $urandom;
            en_r  = $urandom_range(0, 1) == 1;
            drive(1'b0, en_r, ps_r, tgt_r, gnt_r, rv_r, rd_r);

            p_en = en_r; p_ps = ps_r; p_tgt = tgt_r; p_valid = fetch_valid;
            @(posedge clk); #1;
        end
        checks++;
        if (consumed < 100) begin
            errors++;
            $display("FAIL rnd.progress: consumed %0d expected at least 100", consumed);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
